led_seq_ctrl: RTL and testbench

Sequencer for the board status LED. It replaces a fixed free-running blink divider with a small programmable table of (level, duration) steps, which it plays back on a shared millisecond tick. Software or a top-level FSM loads the table, pulses `start`, and sees `busy`/`done`. It sits between the user/control logic and the `led` pin.

---
 rtl/led_seq_pkg.sv | 27 ++
 rtl/led_seq_ctrl_tick_prescaler.sv | 38 +++
 rtl/led_seq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_led_seq_ctrl.sv | 293 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_seq_pkg.sv
// Shared types and default constants for the LED sequencer.
// The loop-playback option is selected by the LED_SEQ_LOOP_EN macro.
package led_seq_pkg;

  // Default clock cycles per tick (1 ms at 100 MHz).
  localparam int DEF_TICK_DIV  = 100_000;
  // Default number of table entries.
  localparam int DEF_NUM_STEPS = 8;
  // Default width of a step duration, in ticks.
  localparam int DEF_DUR_W     = 16;

  // Controller states.
  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LOAD,
    ST_RUN,
    ST_FINISH
  } state_e;

  // One table entry at the default duration width.
  // The controller declares the same shape at its configured width.
  typedef struct packed {
    logic                 level;
    logic [DEF_DUR_W-1:0] dur;
  } step_t;

endpackage

// File: rtl/led_seq_ctrl_tick_prescaler.sv
// Clearable clock divider: counts 0..TICK_DIV-1 while enabled and emits a
// one-cycle tick on the cycle where the count wraps.
module tick_prescaler
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV = DEF_TICK_DIV
) (
  input  logic clk,
  input  logic rst_n,
  input  logic i_clr,
  input  logic i_en,
  output logic o_tick
);

  localparam int               CNT_W    = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICK_DIV - 1);

  logic [CNT_W-1:0] r_cnt;
  logic             w_wrap;

  // The wrap is decoded from the count, never left to counter overflow.
  assign w_wrap = (r_cnt == CNT_LAST);
  assign o_tick = i_en && w_wrap;

  // Divider counter: clear has priority, otherwise count while enabled.
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= w_wrap ? '0 : r_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/led_seq_ctrl.sv
// LED sequencer: plays a table of (level, duration) steps on a shared tick.
// Define LED_SEQ_LOOP_EN to add the loop port and continuous playback.
module led_seq_ctrl
  import led_seq_pkg::*;
#(
  parameter int TICK_DIV  = DEF_TICK_DIV,
  parameter int NUM_STEPS = DEF_NUM_STEPS,
  parameter int DUR_W     = DEF_DUR_W
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         cfg_we,
  input  logic [$clog2(NUM_STEPS)-1:0] cfg_addr,
  input  logic                         cfg_level,
  input  logic [DUR_W-1:0]             cfg_dur,
`ifdef LED_SEQ_LOOP_EN
  input  logic                         loop,
`endif
  output logic                         led,
  output logic                         busy,
  output logic                         done,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx
);

  localparam int               IDX_W    = $clog2(NUM_STEPS);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_STEPS - 1);

  typedef struct packed {
    logic             level;
    logic [DUR_W-1:0] dur;
  } entry_t;

  entry_t           r_tbl [NUM_STEPS];
  state_e           r_state;
  logic [IDX_W-1:0] r_idx;
  logic [DUR_W-1:0] r_rem;
  logic             r_led;
  logic             r_busy;
  logic             r_done;
  logic             r_restart;

  entry_t           w_entry;
  logic             w_tick;
  logic             w_loop_req;
  logic             w_to_finish;

`ifdef LED_SEQ_LOOP_EN
  assign w_loop_req = loop;
`else
  assign w_loop_req = 1'b0;
`endif

  assign w_entry = r_tbl[r_idx];

  // A sequence ends on a zero-duration entry or on the final wrap of the
  // last table slot.
  assign w_to_finish = ((r_state == ST_LOAD) && (w_entry.dur == '0)) ||
                       ((r_state == ST_RUN) && w_tick &&
                        (r_rem == DUR_W'(1)) && (r_idx == IDX_LAST));

  // The prescaler is held at zero through every LOAD cycle so each step's
  // RUN phase starts on a fresh tick boundary.
  tick_prescaler #(
    .TICK_DIV (TICK_DIV)
  ) u_prescaler (
    .clk    (clk),
    .rst_n  (reset),
    .i_clr  (r_state == ST_LOAD),
    .i_en   (r_state == ST_RUN),
    .o_tick (w_tick)
  );

  // Step table: writable only while idle, cleared by reset.
  // NOTE: the table is small enough to live in flops, so it takes the
  // asynchronous reset; a RAM-mapped table could not be cleared this way.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < NUM_STEPS; i++) begin
        r_tbl[i] <= '0;
      end
    end else if (cfg_we && (r_state == ST_IDLE)) begin
      r_tbl[cfg_addr] <= '{level: cfg_level, dur: cfg_dur};
    end
  end

  // Playback FSM with registered led/busy/done/step index.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state   <= ST_IDLE;
      r_idx     <= '0;
      r_rem     <= '0;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_restart <= 1'b0;
    end else if (stop) begin
      // Abort from any state; wins over a simultaneous start.
      r_state   <= ST_IDLE;
      r_led     <= 1'b0;
      r_busy    <= 1'b0;
      r_done    <= 1'b0;
      r_restart <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (w_to_finish) begin
        // The restart decision is taken here so a looping FINISH keeps the
        // LED level and suppresses done.
        r_state   <= ST_FINISH;
        r_busy    <= 1'b0;
        r_rem     <= '0;
        r_restart <= w_loop_req;
        if (!w_loop_req) begin
          r_done <= 1'b1;
          r_led  <= 1'b0;
        end
      end else begin
        unique case (r_state)
          ST_IDLE: begin
            if (start) begin
              r_state <= ST_LOAD;
              r_idx   <= '0;
              r_busy  <= 1'b1;
            end
          end
          ST_LOAD: begin
            r_led   <= w_entry.level;
            r_rem   <= w_entry.dur;
            r_state <= ST_RUN;
          end
          ST_RUN: begin
            if (w_tick && (r_rem != '0)) begin
              r_rem <= r_rem - 1'b1;
              if (r_rem == DUR_W'(1)) begin
                r_idx   <= r_idx + 1'b1;
                r_state <= ST_LOAD;
              end
            end
          end
          ST_FINISH: begin
            r_restart <= 1'b0;
            if (r_restart) begin
              r_idx   <= '0;
              r_busy  <= 1'b1;
              r_state <= ST_LOAD;
            end else begin
              r_state <= ST_IDLE;
            end
          end
        endcase
      end
    end
  end

  assign led      = r_led;
  assign busy     = r_busy;
  assign done     = r_done;
  assign step_idx = r_idx;

endmodule

// File: tb/tb_led_seq_ctrl.sv
// Self-checking bench for led_seq_ctrl (TICK_DIV=4, NUM_STEPS=4).
// Define LED_SEQ_LOOP_EN to include the loop playback scenario.
module tb_led_seq_ctrl;
  import led_seq_pkg::*;

  localparam int TICK_DIV  = 4;
  localparam int NUM_STEPS = 4;
  localparam int DUR_W     = DEF_DUR_W;

  typedef struct packed {
    logic       led;
    logic       busy;
    logic       done;
    logic [1:0] idx;
  } obs_t;

  logic             clk = 1'b0;
  logic             reset;
  logic             start;
  logic             stop;
  logic             cfg_we;
  logic [1:0]       cfg_addr;
  logic             cfg_level;
  logic [DUR_W-1:0] cfg_dur;
`ifdef LED_SEQ_LOOP_EN
  logic             loop;
`endif
  logic             led;
  logic             busy;
  logic             done;
  logic [1:0]       step_idx;

  step_t m_tbl [NUM_STEPS];
  obs_t  exp_q [$];
  int    n_checks  = 0;
  int    n_pass    = 0;
  int    t_cycles  = 0;
  int    t_done_at = -1;
  string tag       = "";

  always #5 clk = ~clk;

  led_seq_ctrl #(
    .TICK_DIV  (TICK_DIV),
    .NUM_STEPS (NUM_STEPS),
    .DUR_W     (DUR_W)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .stop      (stop),
    .cfg_we    (cfg_we),
    .cfg_addr  (cfg_addr),
    .cfg_level (cfg_level),
    .cfg_dur   (cfg_dur),
`ifdef LED_SEQ_LOOP_EN
    .loop      (loop),
`endif
    .led       (led),
    .busy      (busy),
    .done      (done),
    .step_idx  (step_idx)
  );

  task automatic check_obs(input string name, input obs_t exp);
    obs_t act;
    act = {led, busy, done, step_idx};
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed led=%b busy=%b done=%b idx=%0d, expected led=%b busy=%b done=%b idx=%0d",
                name, act.led, act.busy, act.done, act.idx, exp.led, exp.busy, exp.done, exp.idx);
  endtask

  task automatic check_int(input string name, input int act, input int exp);
    n_checks++;
    assert (act === exp) n_pass++;
    else $error("FAIL %s: observed %0d, expected %0d", name, act, exp);
  endtask

  function automatic void push(input logic l, input logic b, input logic d, input int i);
    obs_t o;
    o = {l, b, d, 2'(i)};
    exp_q.push_back(o);
  endfunction

  // Advance one clock; leave the bench just after the edge with pulses cleared.
  task automatic cycle();
    @(posedge clk);
    #1;
    start  = 1'b0;
    stop   = 1'b0;
    cfg_we = 1'b0;
    t_cycles++;
  endtask

  task automatic begin_run();
    t_cycles  = 0;
    t_done_at = -1;
  endtask

  // Pop and compare up to n expected observations, one per cycle.
  task automatic drain_n(input int n);
    obs_t e;
    for (int k = 0; k < n; k++) begin
      if (exp_q.size() == 0) break;
      cycle();
      e = exp_q.pop_front();
      if (done === 1'b1 && t_done_at < 0) t_done_at = t_cycles;
      check_obs($sformatf("%s_c%0d", tag, t_cycles), e);
    end
  endtask

  task automatic drain();
    drain_n(exp_q.size());
  endtask

  task automatic write_entry(input int a, input logic l, input int d);
    cfg_we    = 1'b1;
    cfg_addr  = 2'(a);
    cfg_level = l;
    cfg_dur   = DUR_W'(d);
    m_tbl[a].level = l;
    m_tbl[a].dur   = DUR_W'(d);
    cycle();
  endtask

  // Expected per-cycle trace from the table model, starting with the first
  // LOAD after start. n_loops FINISH cycles restart instead of ending.
  task automatic expect_play(input int n_loops);
    logic lvl;
    int   i;
    int   loops;
    bit   fin;
    bit   again;
    lvl   = 1'b0;
    loops = n_loops;
    do begin
      i   = 0;
      fin = 1'b0;
      while (!fin) begin
        push(lvl, 1'b1, 1'b0, i);
        if (m_tbl[i].dur == '0) begin
          fin = 1'b1;
        end else begin
          lvl = m_tbl[i].level;
          repeat (int'(m_tbl[i].dur) * TICK_DIV) push(lvl, 1'b1, 1'b0, i);
          if (i == NUM_STEPS - 1) fin = 1'b1;
          else i++;
        end
      end
      again = (loops > 0);
      if (again) begin
        push(lvl, 1'b0, 1'b0, i);
        loops--;
      end else begin
        push(1'b0, 1'b0, 1'b1, i);
        push(1'b0, 1'b0, 1'b0, i);
      end
    end while (again);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset     = 1'b0;
    start     = 1'b0;
    stop      = 1'b0;
    cfg_we    = 1'b0;
    cfg_addr  = '0;
    cfg_level = 1'b0;
    cfg_dur   = '0;
`ifdef LED_SEQ_LOOP_EN
    loop      = 1'b0;
`endif
    for (int i = 0; i < NUM_STEPS; i++) m_tbl[i] = '0;

    // Reset values.
    #2;
    check_obs("reset", '0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;

    // Basic playback: led high 9 cycles, low 5, done at cycle 16.
    write_entry(0, 1'b1, 2);
    write_entry(1, 1'b0, 1);
    write_entry(2, 1'b0, 0);
    tag = "basic";
    expect_play(0);
    begin_run();
    start = 1'b1;
    drain();
    check_int("basic_latency", t_done_at, 16);

    // Empty table: LOAD then FINISH.
    write_entry(0, 1'b0, 0);
    tag = "empty";
    expect_play(0);
    begin_run();
    start = 1'b1;
    drain();
    check_int("empty_latency", t_done_at, 2);

    // Full table: all four slots, finish after the step-3 wrap.
    write_entry(0, 1'b1, 1);
    write_entry(1, 1'b0, 1);
    write_entry(2, 1'b1, 1);
    write_entry(3, 1'b0, 1);
    tag = "full";
    expect_play(0);
    begin_run();
    start = 1'b1;
    drain();
    check_int("full_latency", t_done_at, 21);

    // Stop during step 0 RUN, then start+stop together from IDLE.
    write_entry(0, 1'b1, 2);
    tag = "stop";
    push(1'b0, 1'b1, 1'b0, 0);
    repeat (3) push(1'b1, 1'b1, 1'b0, 0);
    begin_run();
    start = 1'b1;
    drain();
    stop = 1'b1;
    cycle();
    check_obs("stop_next", '0);
    repeat (4) push(1'b0, 1'b0, 1'b0, 0);
    drain();
    tag = "start_stop";
    start = 1'b1;
    stop  = 1'b1;
    repeat (3) push(1'b0, 1'b0, 1'b0, 0);
    drain();

    // Table write and second start while busy are both ignored.
    write_entry(0, 1'b1, 2);
    write_entry(1, 1'b0, 1);
    write_entry(2, 1'b0, 0);
    tag = "busy_wr";
    expect_play(0);
    begin_run();
    start = 1'b1;
    drain_n(2);
    cfg_we    = 1'b1;
    cfg_addr  = 2'd1;
    cfg_level = 1'b1;
    cfg_dur   = DUR_W'(3);
    start     = 1'b1;
    drain();
    check_int("busy_wr_latency", t_done_at, 16);

    // Asynchronous reset mid-playback clears outputs and the table.
    tag = "arst";
    start = 1'b1;
    repeat (4) cycle();
    #3;
    reset = 1'b0;
    #1;
    check_obs("arst_async", '0);
    cycle();
    reset = 1'b1;
    for (int i = 0; i < NUM_STEPS; i++) m_tbl[i] = '0;
    tag = "arst_replay";
    expect_play(0);
    begin_run();
    start = 1'b1;
    drain();

`ifdef LED_SEQ_LOOP_EN
    // Loop: two-step table replays without done until loop drops.
    write_entry(0, 1'b1, 1);
    write_entry(1, 1'b0, 1);
    write_entry(2, 1'b0, 0);
    tag  = "loop";
    loop = 1'b1;
    expect_play(1);
    begin_run();
    start = 1'b1;
    drain_n(15);
    loop = 1'b0;
    drain();
    check_int("loop_latency", t_done_at, 24);
`endif

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
